// File: rtl/a2pdp11_pkg.sv
// rtl/a2pdp11_pkg.sv - shared types and constants for the J11-to-Apple II transmit path
package a2pdp11_pkg;

    // Apple II output handshake states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } tx_state_t;

    // XCSR bit positions
    localparam int XCSR_DONE_BIT = 7;
    localparam int XCSR_IE_BIT   = 6;

    // J11 general-purpose bus code for INIT
    localparam logic [7:0] GP_INIT = 8'o014;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte-wide circular FIFO with occupancy count and synchronous clear
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle; the count, not the pointers, tells full from empty
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; clear collapses write onto read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (clear) begin
                wr_ptr <= rd_ptr;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage array, deliberately left without reset
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dlart_tx_fifo.sv
// rtl/dlart_tx_fifo.sv - DLART transmit FIFO, XCSR and Apple II handshake; DLART_XINT_EN enables xirq
module dlart_tx_fifo
    import a2pdp11_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   csr_wr,
    input  logic [7:0]             csr_wdata,
    output logic [7:0]             xcsr_rdata,
    output logic                   xdone,
    output logic                   a2_xstb,
    output logic [7:0]             a2_xbuf,
    input  logic                   a2_xrdy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun,
    output logic                   xirq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    tx_state_t     state;
    logic          fifo_push;
    logic          fifo_pop;
    logic          load;
    logic          drop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    head;
    logic [7:0]    load_data;
    logic [CW-1:0] count_next;
    logic          xdone_next;
    logic          ie;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign xdone_next = (count_next != FULL_COUNT);

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (init),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .wr_data    (wr_data),
        .rd_data    (head),
        .count      (fifo_count),
        .count_next (count_next)
    );

    // Decide this cycle's pop, push, drop, and whether an empty idle FIFO bypasses wr_data to the Apple II
    always_comb begin
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        load      = 1'b0;
        load_data = head;
        drop      = 1'b0;
        if (!init) begin
            if (state == IDLE) begin
                if (!fifo_empty) begin
                    load     = 1'b1;
                    fifo_pop = 1'b1;
                end else if (wr_en) begin
                    load      = 1'b1;
                    load_data = wr_data;
                end
            end
            if (wr_en && !(load && fifo_empty)) begin
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Apple II handshake: present a byte, wait for acknowledge, wait for its release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a2_xstb <= 1'b0;
            a2_xbuf <= 8'h00;
        end else if (init) begin
            state   <= IDLE;
            a2_xstb <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        a2_xbuf <= load_data;
                        a2_xstb <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (a2_xrdy) begin
                        a2_xstb <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!a2_xrdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    a2_xstb <= 1'b0;
                end
            endcase
        end
    end

    // Ready flag tracks the post-update count; overrun is sticky until INIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xdone   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            xdone <= xdone_next;
            if (init) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef DLART_XINT_EN
    logic ie_next;
    logic unused_csr;

    assign unused_csr = ^{csr_wdata[7], csr_wdata[5:0]};

    // Interrupt enable as it will stand after this cycle
    always_comb begin
        ie_next = ie;
        if (init) begin
            ie_next = 1'b0;
        end else if (csr_wr) begin
            ie_next = csr_wdata[XCSR_IE_BIT];
        end
    end

    // Interrupt enable and level interrupt, both registered from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie   <= 1'b0;
            xirq <= 1'b0;
        end else begin
            ie   <= ie_next;
            xirq <= ie_next & xdone_next;
        end
    end
`else
    logic unused_csr;

    assign unused_csr = ^{csr_wr, csr_wdata};
    assign ie         = 1'b0;
    assign xirq       = 1'b0;
`endif

    // XCSR read view: done is read-only, IE reflects the enable register
    always_comb begin
        xcsr_rdata                = 8'h00;
        xcsr_rdata[XCSR_DONE_BIT] = xdone;
        xcsr_rdata[XCSR_IE_BIT]   = ie;
    end

endmodule

// File: tb/tb_dlart_tx_fifo.sv
// tb/tb_dlart_tx_fifo.sv - directed table-driven bench for dlart_tx_fifo
module tb_dlart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       init;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       csr_wr;
    logic [7:0] csr_wdata;
    logic [7:0] xcsr_rdata;
    logic       xdone;
    logic       a2_xstb;
    logic [7:0] a2_xbuf;
    logic       a2_xrdy;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       xirq;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       init;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       xrdy;
        logic       xstb;
        logic [7:0] xbuf;
        int         cnt;
        logic       done;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    dlart_tx_fifo #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .csr_wr     (csr_wr),
        .csr_wdata  (csr_wdata),
        .xcsr_rdata (xcsr_rdata),
        .xdone      (xdone),
        .a2_xstb    (a2_xstb),
        .a2_xbuf    (a2_xbuf),
        .a2_xrdy    (a2_xrdy),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .xirq       (xirq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic i, input logic w, input logic [7:0] d, input logic r,
                       input logic s, input logic [7:0] b, input int c, input logic dn, input logic o);
        vec_t v;
        v.init = i; v.wr_en = w; v.wr_data = d; v.xrdy = r;
        v.xstb = s; v.xbuf = b; v.cnt = c; v.done = dn; v.ovr = o;
        vecs.push_back(v);
    endtask

    task automatic step(input logic i, input logic w, input logic [7:0] d,
                        input logic cw, input logic [7:0] cd, input logic r);
        init = i; wr_en = w; wr_data = d; csr_wr = cw; csr_wdata = cd; a2_xrdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic s, input logic [7:0] b,
                              input int c, input logic dn, input logic o);
        check({tag, ".xstb"},  32'(a2_xstb),    32'(s));
        check({tag, ".xbuf"},  32'(a2_xbuf),    32'(b));
        check({tag, ".count"}, 32'(fifo_count), 32'(c));
        check({tag, ".xdone"}, 32'(xdone),      32'(dn));
        check({tag, ".ovr"},   32'(overrun),    32'(o));
    endtask

    initial begin
        logic [7:0] cur;
        int         c;
        logic [7:0] exp_csr;
        logic       exp_irq;

        rst_n = 1'b0; init = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        csr_wr = 1'b0; csr_wdata = 8'h00; a2_xrdy = 1'b0;

        // Simple write/handshake, then xrdy ignored while idle
        add(0, 1, 8'h41, 0, 1, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 0, 1, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 8'h41, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h41, 0, 1, 0);
        // Nine writes with xrdy low: one presented, eight stored, full
        add(0, 1, 8'h10, 0, 1, 8'h10, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 8'h11 + 8'(k), 0, 1, 8'h10, k + 1, (k + 1) < 8, 0);
        end
        add(0, 0, 8'h00, 1, 0, 8'h10, 8, 0, 0);
        add(0, 0, 8'h00, 0, 0, 8'h10, 8, 0, 0);
        // Write while full with an idle pop: accepted, no overrun
        add(0, 1, 8'h19, 0, 1, 8'h11, 8, 0, 0);
        // Write while full in PRESENT: dropped, overrun set
        add(0, 1, 8'h1A, 0, 1, 8'h11, 8, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h11, 8, 0, 1);
        // Drain five bytes; order shows the stored contents were not disturbed
        cur = 8'h11;
        c = 8;
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 8'h00, 1, 0, cur, c, c < 8, 1);
            add(0, 0, 8'h00, 0, 0, cur, c, c < 8, 1);
            cur = 8'h12 + 8'(k);
            c = c - 1;
            add(0, 0, 8'h00, 0, 1, cur, c, 1, 1);
        end
        // INIT in PRESENT with three bytes queued, same-cycle write loses
        add(1, 1, 8'hEE, 0, 0, 8'h16, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h16, 0, 1, 0);
        // Bytes 01..05 queued across the pointer wrap, then handed over in order
        add(0, 1, 8'h01, 0, 1, 8'h01, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 8'h02 + 8'(k), 0, 1, 8'h01, k + 1, 1, 0);
        end
        cur = 8'h01;
        c = 4;
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 8'h00, 1, 0, cur, c, 1, 0);
            add(0, 0, 8'h00, 0, 0, cur, c, 1, 0);
            cur = cur + 8'h01;
            c = c - 1;
            add(0, 0, 8'h00, 0, 1, cur, c, 1, 0);
        end
        add(0, 0, 8'h00, 1, 0, 8'h05, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h05, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h05, 0, 1, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 8'h00, 0, 1, 0);
        check("reset.xirq", 32'(xirq), 32'd0);
        check("reset.xcsr", 32'(xcsr_rdata), 32'h80);
        #3;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].init, vecs[i].wr_en, vecs[i].wr_data, 1'b0, 8'h00, vecs[i].xrdy);
            check_outs($sformatf("v%0d", i), vecs[i].xstb, vecs[i].xbuf,
                       vecs[i].cnt, vecs[i].done, vecs[i].ovr);
        end

        // CSR write of IE with an empty FIFO
`ifdef DLART_XINT_EN
        exp_csr = 8'hC0;
        exp_irq = 1'b1;
`else
        exp_csr = 8'h80;
        exp_irq = 1'b0;
`endif
        step(0, 0, 8'h00, 1, 8'h40, 0);
        check("ie.xcsr", 32'(xcsr_rdata), 32'(exp_csr));
        check("ie.xirq", 32'(xirq), 32'(exp_irq));

        // Fill to full plus one: interrupt falls with xdone, overrun set
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 8'h60 + 8'(k), 0, 8'h00, 0);
        end
        check_outs("full", 1, 8'h60, 8, 0, 1);
        check("full.xcsr", 32'(xcsr_rdata), 32'(exp_csr & 8'h40));
        check("full.xirq", 32'(xirq), 32'd0);

        // INIT beats a same-cycle CSR write and clears everything
        step(1, 0, 8'h00, 1, 8'h40, 0);
        check_outs("init", 0, 8'h60, 0, 1, 0);
        check("init.xcsr", 32'(xcsr_rdata), 32'h80);
        check("init.xirq", 32'(xirq), 32'd0);

        // Asynchronous reset mid-cycle while a byte is presented
        step(0, 1, 8'h77, 0, 8'h00, 0);
        check_outs("pre_rst", 1, 8'h77, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 8'h00, 0, 1, 0);
        check("async_rst.xcsr", 32'(xcsr_rdata), 32'h80);
        #1;
        rst_n = 1'b1;
        step(0, 0, 8'h00, 0, 8'h00, 0);
        check_outs("post_rst", 0, 8'h00, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
